main_memory: RTL and testbench
==============================

# main_memory

Cycle-accurate main-memory responder at the far end of the MMU memory bus. Accepts line-granular read and write requests on the `mem_req_*` side, applies writes immediately, and queues reads. Serves queued reads in order with a fixed service latency, returning them as single-cycle `mem_rec_*` responses. It is the memory-side counterpart of the bus delay line and is instantiated in the top-level testbench and SoC wrapper directly on the bus's `mem_*` ports.

## Interface
- `LINES`, default 256: number of cachelines stored; must be a power of two.
- `LATENCY`, default 4: cycles from service start to response; must be ≥ 2.
- `DEPTH`, default 8: read-queue entries, excluding the request in service; must be a power of two.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_req_ren`  in  1  read request valid this cycle.
- `mem_req_raddr`  in  pptr_t  read byte address.
- `mem_req_wen`  in  1  write request valid this cycle.
- `mem_req_waddr`  in  pptr_t  write byte address.
- `mem_req_wcacheline`  in  cacheline_t  write data, full line.
- `mem_rec_en`  out  1  response valid; single-cycle pulse.
- `mem_rec_addr`  out  pptr_t  address of the request being answered, as received.
- `mem_rec_cacheline`  out  cacheline_t  line data.
- `overflow`  out  1  sticky; set when a read is dropped.
- `pending`  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- Line index is `addr >> $clog2(CACHELINE_BYTES)`, taken modulo `LINES`. Offset bits are ignored.
- There is no backpressure; a read and a write may arrive in the same cycle.
- **Writes:** the array is updated at the edge ending the request cycle. Array contents are not cleared by reset.
- **Read acceptance** (evaluated at the edge ending the request cycle):
  - If the FSM is IDLE and the queue is empty, the read enters service directly.
  - Otherwise it is pushed to the tail of the queue.
  - If the queue is full and no pop happens that edge, the read is dropped and `overflow` is set.
  - A push and a pop on the same edge while full is accepted.
- **FSM states:**
  - IDLE: no read in service.
  - BUSY: read in service; counter `cnt` is loaded with `LATENCY-1` and decrements each cycle.
  - BUSY with `cnt==0`: `mem_rec_en` is high for that one cycle, with the addr and data of the serviced read.
  - At that same edge, the queue head (or a direct arrival if the queue is empty) enters service and `cnt` reloads. If there is nothing to serve, the FSM returns to IDLE.
- **Read data** is the array contents at the response cycle. It includes all writes accepted at earlier edges and excludes any write in the response cycle itself.
- **Reset** (any time, including mid-service):
  - FSM goes to IDLE and the queue empties; in-flight reads are discarded.
  - `mem_rec_en`=0, `mem_rec_addr`=0, `mem_rec_cacheline`=0, `overflow`=0, `pending`=0.
- `mem_rec_addr` and `mem_rec_cacheline` hold their last values when `mem_rec_en` is low.

## Timing
- Unloaded read at cycle t: response at cycle t+LATENCY.
- Under saturation, responses are spaced exactly `LATENCY` cycles apart, in request order.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `pending` reflects pushes and pops from the preceding edge.

## Structure
- `pptr_t`, `cacheline_t` and `CACHELINE_BYTES` live in `common`. The `rd_entry_t` struct (pptr_t addr) is added there.
- Sub-module `req_fifo`: parameterised synchronous FIFO with push, pop, full, empty and count. Pointers wrap modulo `DEPTH` and use an extra bit to tell full from empty.
- The array, FSM and counter stay in `main_memory`.

## Test plan
- Reset, then write line 0x40 with pattern A, then read 0x40 at cycle t (LATENCY=4). Required: `mem_rec_en` at t+4, addr 0x40, data A; no other pulse.
- Read 0x80 and read 0x80+offset 0x1C. Required: both return the same line; `mem_rec_addr` echoes each exact address.
- Write B to 0x100, then a read of 0x100 is pending. A write of C to 0x100 lands 2 cycles before the response, and a write of D lands in the response cycle. Required: the response returns C.
- Reads every cycle for 20 cycles (DEPTH=8, LATENCY=4). Required: responses spaced 4 apart and in order, `pending` saturates at 8, `overflow` set, dropped reads never answered.
- Assert `rst` for 1 cycle while BUSY with 3 queued. Required: outputs 0 in the next cycle, no further responses, array contents intact on a later read.
- A read and a write to different lines in the same cycle. Required: the write takes effect and the read returns its own line after 4 cycles.

Source files
------------

// File: rtl/main_memory_pkg.sv
// main_memory_pkg: shared bus types, line geometry and the read-queue entry for main_memory.
package main_memory_pkg;
    localparam int PPTR_W = 32;
    localparam int CACHELINE_BYTES = 64;
    typedef logic [PPTR_W-1:0] pptr_t;
    typedef logic [CACHELINE_BYTES*8-1:0] cacheline_t;
    typedef struct packed {
        pptr_t addr;
    } rd_entry_t;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/main_memory_if.sv
// main_memory_if: memory bus between the MMU-side requester (master) and main_memory (slave).
// Request side: mem_req_ren/raddr (read), mem_req_wen/waddr/wcacheline (write).
// Response side: mem_rec_en pulse with mem_rec_addr and mem_rec_cacheline.
interface main_memory_if;
    import main_memory_pkg::*;
    logic       mem_req_ren;
    pptr_t      mem_req_raddr;
    logic       mem_req_wen;
    pptr_t      mem_req_waddr;
    cacheline_t mem_req_wcacheline;
    logic       mem_rec_en;
    pptr_t      mem_rec_addr;
    cacheline_t mem_rec_cacheline;
    modport master (
        output mem_req_ren, mem_req_raddr, mem_req_wen, mem_req_waddr, mem_req_wcacheline,
        input  mem_rec_en, mem_rec_addr, mem_rec_cacheline
    );
    modport slave (
        input  mem_req_ren, mem_req_raddr, mem_req_wen, mem_req_waddr, mem_req_wcacheline,
        output mem_rec_en, mem_rec_addr, mem_rec_cacheline
    );
endinterface

// File: rtl/main_memory_req_fifo.sv
// req_fifo: synchronous FIFO with push, pop, full, empty and occupancy count.
// Ports: clk, rst (async active-high), push/din, pop/dout (head, valid when !empty),
// full, empty, count. Pointers carry one extra wrap bit so full and empty differ.
// A push while full is accepted only when a pop happens on the same edge.
module req_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;
    assign count   = wr_ptr - rd_ptr;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/main_memory.sv
// main_memory: line-granular memory responder; writes apply at once, reads are queued
// and answered in order after a fixed LATENCY as single-cycle responses.
// Ports: clk, rst (async active-high), bus (main_memory_if.slave: mem_req_* in,
// mem_rec_* out), overflow (sticky, a read was dropped), pending (queue occupancy).
module main_memory
    import main_memory_pkg::*;
#(
    parameter int LINES   = 256,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    main_memory_if.slave           bus,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] pending
);
    localparam int LW  = $clog2(LINES);
    localparam int CW  = $clog2(LATENCY);
    localparam int OFF = $clog2(CACHELINE_BYTES);
    cacheline_t mem [LINES];
    state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    pptr_t      cur_addr, cur_addr_n;
    logic       resp, start, push, pop, full, empty, emit;
    rd_entry_t  head, arrival;
    logic [LW-1:0] widx, cidx;
    assign widx    = LW'(bus.mem_req_waddr >> OFF);
    assign cidx    = LW'(cur_addr >> OFF);
    assign arrival = '{addr: bus.mem_req_raddr};
    // The output registers are loaded one edge ahead of the response cycle, so the
    // write landing on that edge is forwarded to keep "all earlier writes" semantics.
    assign emit    = state == BUSY && cnt == CW'(1);
    req_fifo #(.W($bits(rd_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst),
        .push(push), .din(arrival),
        .pop(pop), .dout(head),
        .full(full), .empty(empty), .count(pending)
    );
    always_comb begin
        resp       = state == BUSY && cnt == '0;
        start      = state == IDLE || resp;
        pop        = start && !empty;
        push       = bus.mem_req_ren && !(start && empty);
        state_n    = state;
        cnt_n      = state == BUSY ? cnt - 1'b1 : cnt;
        cur_addr_n = cur_addr;
        if (start) begin
            state_n    = (!empty || bus.mem_req_ren) ? BUSY : IDLE;
            cnt_n      = CW'(LATENCY - 1);
            cur_addr_n = !empty ? head.addr : bus.mem_req_raddr;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_addr <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_addr <= cur_addr_n;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_rec_en        <= 1'b0;
            bus.mem_rec_addr      <= '0;
            bus.mem_rec_cacheline <= '0;
        end else begin
            bus.mem_rec_en <= emit;
            if (emit) begin
                bus.mem_rec_addr      <= cur_addr;
                bus.mem_rec_cacheline <= (bus.mem_req_wen && widx == cidx) ? bus.mem_req_wcacheline : mem[cidx];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (bus.mem_req_wen) mem[widx] <= bus.mem_req_wcacheline;
    end
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: randomized and directed bench for main_memory against a response-schedule model.
module tb_main_memory;
    import main_memory_pkg::*;
    localparam int LAT = 4;
    localparam int DEP = 8;
    localparam int NL  = 256;
    typedef struct {
        pptr_t  addr;
        longint t;
        longint r;
    } rd_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow;
    logic [$clog2(DEP):0] pending;
    main_memory_if bus();
    main_memory #(.LINES(NL), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .bus(bus), .overflow(overflow), .pending(pending)
    );
    always #5 clk = ~clk;

    rd_t        recs[$];
    cacheline_t mdl [NL];
    longint     cyc = 0, last_r = 0;
    pptr_t      last_addr = '0;
    cacheline_t last_line = '0;
    logic       ovf_m = 1'b0;
    int         chk = 0, err = 0, max_pend = 0;
    longint     obs_cyc[$];
    pptr_t      obs_addr[$];
    cacheline_t obs_line[$];

    function automatic int idx(pptr_t a);
        return int'((a / CACHELINE_BYTES) % NL);
    endfunction

    function automatic cacheline_t rnd_line();
        cacheline_t l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: compare the outputs of the current cycle, drive this cycle's
    // inputs, advance the model across the edge that ends the cycle.
    task automatic step(input bit ren, input pptr_t ra, input bit wen, input pptr_t wa,
                        input cacheline_t wd, input bit r);
        int q, exp_pend;
        longint s;
        bit hit;
        hit = recs.size() > 0 && recs[0].r == cyc;
        if (hit) begin
            last_addr = recs[0].addr;
            last_line = mdl[idx(recs[0].addr)];
            void'(recs.pop_front());
        end
        exp_pend = 0;
        foreach (recs[i]) if (recs[i].r - LAT >= cyc) exp_pend++;
        check("rec_en", 512'(bus.mem_rec_en), 512'(hit));
        check("rec_addr", 512'(bus.mem_rec_addr), 512'(last_addr));
        check("rec_line", bus.mem_rec_cacheline, last_line);
        check("overflow", 512'(overflow), 512'(ovf_m));
        check("pending", 512'(pending), 512'(exp_pend));
        if (bus.mem_rec_en === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_addr.push_back(bus.mem_rec_addr);
            obs_line.push_back(bus.mem_rec_cacheline);
        end
        if (int'(pending) > max_pend) max_pend = int'(pending);
        bus.mem_req_ren        = ren;
        bus.mem_req_raddr      = ra;
        bus.mem_req_wen        = wen;
        bus.mem_req_waddr      = wa;
        bus.mem_req_wcacheline = wd;
        rst                    = r;
        if (wen) mdl[idx(wa)] = wd;
        if (r) begin
            recs.delete();
            last_addr = '0;
            last_line = '0;
            ovf_m     = 1'b0;
            last_r    = 0;
        end else if (ren) begin
            s = cyc > last_r ? cyc : last_r;
            q = 0;
            foreach (recs[i]) if (recs[i].r - LAT > cyc) q++;
            if (s > cyc && q >= DEP) ovf_m = 1'b1;
            else begin
                recs.push_back('{addr: ra, t: cyc, r: s + LAT});
                last_r = s + LAT;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        cacheline_t a, b, c, d, e, f;
        longint t;
        int n0, rr;
        int acc_k[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 16};
        bus.mem_req_ren = 0; bus.mem_req_raddr = '0; bus.mem_req_wen = 0;
        bus.mem_req_waddr = '0; bus.mem_req_wcacheline = '0;
        a = {16{32'hA1A2A3A4}}; b = {16{32'hB0B0B0B0}}; c = {16{32'hC3C3C3C3}};
        d = {16{32'hD4D4D4D4}}; e = {16{32'hE5E5E5E5}}; f = {16{32'h0F0F1234}};
        @(negedge clk);
        check("reset_en", 512'(bus.mem_rec_en), 512'(0));
        check("reset_pending", 512'(pending), 512'(0));
        step(0, '0, 0, '0, '0, 1);
        step(0, '0, 0, '0, '0, 0);
        for (int i = 0; i < NL; i++) step(0, '0, 1, pptr_t'(i * CACHELINE_BYTES), rnd_line(), 0);
        // unloaded read of a freshly written line
        step(0, '0, 1, 32'h40, a, 0);
        idle(1);
        n0 = obs_cyc.size(); t = cyc;
        step(1, 32'h40, 0, '0, '0, 0);
        idle(7);
        check("t1_count", 512'(obs_cyc.size() - n0), 512'(1));
        check("t1_cycle", 512'(obs_cyc[$]), 512'(t + 4));
        check("t1_addr", 512'(obs_addr[$]), 512'(32'h40));
        check("t1_line", obs_line[$], a);
        // offset bits ignored, exact address echoed
        step(1, 32'h80, 0, '0, '0, 0);
        step(1, 32'h9C, 0, '0, '0, 0);
        idle(10);
        check("off_addr0", 512'(obs_addr[$-1]), 512'(32'h80));
        check("off_addr1", 512'(obs_addr[$]), 512'(32'h9C));
        check("off_same_line", obs_line[$], obs_line[$-1]);
        // writes landing before and during the response cycle
        step(0, '0, 1, 32'h100, b, 0);
        idle(1);
        t = cyc;
        step(1, 32'h100, 0, '0, '0, 0);
        idle(1);
        step(0, '0, 1, 32'h100, c, 0);
        idle(1);
        step(0, '0, 1, 32'h100, d, 0);
        idle(4);
        check("fwd_cycle", 512'(obs_cyc[$]), 512'(t + 4));
        check("fwd_line", obs_line[$], c);
        // saturation: read every cycle for 20 cycles
        max_pend = 0; n0 = obs_cyc.size();
        for (int k = 0; k < 20; k++) step(1, pptr_t'(32'h1000 + k * 64), 0, '0, '0, 0);
        idle(60);
        check("sat_count", 512'(obs_cyc.size() - n0), 512'(13));
        check("sat_max_pending", 512'(max_pend), 512'(8));
        check("sat_overflow", 512'(overflow), 512'(1));
        for (int i = 0; i < 13; i++) begin
            check("sat_order", 512'(obs_addr[n0 + i]), 512'(32'h1000 + acc_k[i] * 64));
            if (i > 0) check("sat_spacing", 512'(obs_cyc[n0 + i] - obs_cyc[n0 + i - 1]), 512'(4));
        end
        // reset while busy with three queued
        for (int k = 0; k < 4; k++) step(1, pptr_t'(32'h1000 + k * 64), 0, '0, '0, 0);
        check("pre_rst_pending", 512'(pending), 512'(3));
        step(0, '0, 0, '0, '0, 1);
        n0 = obs_cyc.size();
        idle(20);
        check("rst_no_resp", 512'(obs_cyc.size() - n0), 512'(0));
        check("rst_ovf_clear", 512'(overflow), 512'(0));
        step(1, 32'h40, 0, '0, '0, 0);
        idle(6);
        check("rst_array_kept", obs_line[$], a);
        // read and write to different lines in one cycle
        step(0, '0, 1, 32'h2000, f, 0);
        t = cyc;
        step(1, 32'h2000, 1, 32'h3040, e, 0);
        idle(5);
        check("rw_cycle", 512'(obs_cyc[$]), 512'(t + 4));
        check("rw_line", obs_line[$], f);
        step(1, 32'h3040, 0, '0, '0, 0);
        idle(6);
        check("rw_written", obs_line[$], e);
        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rr = int'($urandom_range(199));
            step($urandom_range(99) < 40, $urandom, $urandom_range(99) < 30, $urandom, rnd_line(), rr == 0);
        end
        idle(60);
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
